bp_pht: RTL and testbench
=========================

# bp_pht

Parametrised pattern history table for conditional-branch direction prediction. Holds `ENTRIES` saturating counters of `CTR_BITS` bits each, with optional gshare indexing. It sits between fetch, which issues a combinational lookup, and retire, which issues in-order updates from the ROB. A sequenced clear sweep lets software or recovery logic re-initialise the table without a global reset.

## Interface
Parameters:
- `ENTRIES`, 64: counter count; power of two, at least 4. `IDX_BITS = $clog2(ENTRIES)`.
- `CTR_BITS`, 2: counter width, 1 to 4. The prediction is the counter MSB.
- `HIST_BITS`, 6: global history length, 0 to `IDX_BITS`. A value of 0 gives pure bimodal indexing.
- `PC_ALIGN`, 2: number of low PC bits dropped before indexing.
- `INIT_CTR`, 0: counter value after reset or clear (0 = strongly not-taken).

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `pred_valid` in 1: fetch lookup request.
- `pred_pc` in 32: PC of the branch being predicted.
- `pred_taken` out 1: predicted direction.
- `pred_index` out `IDX_BITS`: table index used. Fetch carries it through the ROB.
- `upd_valid` in 1: retire update of one resolved conditional branch.
- `upd_index` in `IDX_BITS`: index returned from `pred_index`.
- `upd_taken` in 1: actual branch outcome.
- `clear_req` in 1: start a clear sweep (single-cycle pulse or level).
- `busy` out 1: high while the sweep is in progress.
- `ghr` out `max(HIST_BITS,1)`: current global history, for debug and checkpointing.

## Operation
- Index: `pred_index = pred_pc[PC_ALIGN +: IDX_BITS] ^ {zeros, ghr[HIST_BITS-1:0]}`. When `HIST_BITS=0`, no XOR is applied.
- Prediction: `pred_taken = ctr[pred_index][CTR_BITS-1]` when `pred_valid && !busy`; otherwise 0. `pred_index` is always driven.
- Update, on `upd_valid && !busy`:
  - Taken: `ctr[upd_index]` increments, saturating at `2^CTR_BITS-1`.
  - Not taken: it decrements, saturating at 0.
  - Only one entry is written.
  - The GHR shifts left with `upd_taken` entering bit 0. History is non-speculative: the GHR changes only at retire.
- Same-cycle bypass: if `upd_valid` and `pred_index == upd_index`, `pred_taken` is the MSB of the post-update counter value. `pred_index` itself uses the pre-shift GHR.
- Clear FSM, states `IDLE` and `CLEAR`:
  - `IDLE -> CLEAR` on `clear_req`. The pointer is loaded to 0 and `busy` goes high the following cycle.
  - In `CLEAR`, one entry per cycle is written with `INIT_CTR`, and the pointer increments.
  - The GHR is zeroed on the first `CLEAR` cycle.
  - `CLEAR -> IDLE` after writing entry `ENTRIES-1`. The pointer wraps to 0.
  - `clear_req` asserted during `CLEAR` is ignored; the sweep is not restarted.
- During `busy`:
  - `upd_valid` is dropped: no counter or GHR change.
  - `pred_taken` is 0.
- Reset:
  - All counters are set to `INIT_CTR` in one cycle, the GHR to 0, and the FSM to `IDLE`.
  - Reset mid-sweep aborts the sweep, and the table is fully initialised by reset itself.
- Reset output values: `pred_taken=0`, `busy=0`, `ghr=0`. `pred_index` is the combinational value of `pred_pc` (history 0).

## Timing
- Lookup latency: 0 cycles, combinational from `pred_pc`.
- An update is visible to a different-index lookup on the cycle after `upd_valid`, and to a same-index lookup in the same cycle (bypass).
- A GHR shift affects `pred_index` from the next cycle.
- Clear: `clear_req` at cycle t gives `busy` high on cycles t+1 through t+`ENTRIES`, and low at t+`ENTRIES`+1.
- A `clear_req` and an `upd_valid` in the same `IDLE` cycle: the update is applied, then the sweep starts and overwrites it.

## Structure
- Package `bp_pkg` holds:
  - default parameter constants;
  - a `bp_ctr_t` typedef (width set by the `CTR_BITS` parameter default);
  - a `bp_clr_state_e` enum (`IDLE`, `CLEAR`).
- Sub-module `bp_sat_ctr`: a combinational saturating increment/decrement of one counter, with parameter `CTR_BITS`, inputs `cur`/`take`, output `nxt`. It is shared by the write path and the bypass path.
- The counter array is a flop array with a single write port. The clear sweep and the update share that port, with clear having priority.

## Test plan
- Reset, then lookups of PCs 0x0 through 0xFC with `HIST_BITS=0` → `pred_taken=0` at all 64 indices and `busy=0`.
- Three taken updates to index 5 with `CTR_BITS=2` → counter 0→1→2→3. The prediction flips to 1 after the 2nd update, and a 4th taken update leaves the counter at 3.
- Index 5 at 3, then three not-taken updates → counter 2→1→0. The prediction is 0 after the 2nd update, and a 4th leaves the counter at 0.
- Counter at 1 (WN), taken update to index 9 and same-cycle lookup of PC 0x24 → `pred_taken=1` in that same cycle (bypass).
- `HIST_BITS=6`, updates taken, not-taken, taken → `ghr=6'b000101`. A lookup of PC 0x40 then gives `pred_index=16^5=21`.
- All entries trained to 3, then `clear_req` pulse:
  - `busy` is high for exactly 64 cycles.
  - Updates and lookups during the sweep are ignored or return 0.
  - Afterwards all entries predict 0 and `ghr=0`.
  - A reset asserted mid-sweep drops `busy` the next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults, counter type and clear-FSM states for the pattern history table
package bp_pkg;

  localparam int BP_ENTRIES   = 64;
  localparam int BP_CTR_BITS  = 2;
  localparam int BP_HIST_BITS = 6;
  localparam int BP_PC_ALIGN  = 2;
  localparam int BP_INIT_CTR  = 0;

  typedef logic [BP_CTR_BITS-1:0] bp_ctr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bp_clr_state_e;

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - combinational saturating increment/decrement of one counter
module bp_sat_ctr #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur,
  input  logic                take,
  output logic [CTR_BITS-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (take && (cur != {CTR_BITS{1'b1}})) begin
      nxt = cur + 1'b1;
    end else if (!take && (cur != '0)) begin
      nxt = cur - 1'b1;
    end
  end

endmodule

// File: rtl/bp_pht.sv
// rtl/bp_pht.sv - pattern history table with gshare indexing, retire-time update and a sequenced clear sweep
module bp_pht
  import bp_pkg::*;
#(
  parameter  int ENTRIES   = BP_ENTRIES,
  parameter  int CTR_BITS  = BP_CTR_BITS,
  parameter  int HIST_BITS = BP_HIST_BITS,
  parameter  int PC_ALIGN  = BP_PC_ALIGN,
  parameter  int INIT_CTR  = BP_INIT_CTR,
  localparam int IDX_BITS  = $clog2(ENTRIES),
  localparam int GHR_W     = (HIST_BITS > 0) ? HIST_BITS : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_index,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_index,
  input  logic                upd_taken,
  input  logic                clear_req,
  output logic                busy,
  output logic [GHR_W-1:0]    ghr
);

  localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(INIT_CTR);

  logic [CTR_BITS-1:0] r_ctr [ENTRIES];
  logic [GHR_W-1:0]    r_ghr;
  logic [IDX_BITS-1:0] r_ptr;
  bp_clr_state_e       r_state;
  bp_clr_state_e       w_state_nxt;
  logic                w_busy;
  logic                w_upd_we;
  logic [IDX_BITS-1:0] w_hist_idx;
  logic [CTR_BITS-1:0] w_upd_nxt;
  logic                w_unused_pc;

  // Bits of the PC outside the index window do not participate.
  assign w_unused_pc = ^pred_pc;

  generate
    if (HIST_BITS > 0) begin : g_gshare
      assign w_hist_idx = IDX_BITS'(r_ghr);
    end else begin : g_bimodal
      assign w_hist_idx = '0;
    end
  endgenerate

  assign pred_index = pred_pc[PC_ALIGN +: IDX_BITS] ^ w_hist_idx;
  assign w_upd_we   = upd_valid && !w_busy;
  assign busy       = w_busy;
  assign ghr        = r_ghr;

  // One incrementer serves both the array write and the same-cycle bypass.
  bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
    .cur  (r_ctr[upd_index]),
    .take (upd_taken),
    .nxt  (w_upd_nxt)
  );

  always_comb begin
    pred_taken = 1'b0;
    if (pred_valid && !w_busy) begin
      if (upd_valid && (upd_index == pred_index)) begin
        pred_taken = w_upd_nxt[CTR_BITS-1];
      end else begin
        pred_taken = r_ctr[pred_index][CTR_BITS-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clear_req) w_state_nxt = CLEAR;
      CLEAR:   if (r_ptr == IDX_BITS'(ENTRIES - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == CLEAR);
  end

  // Clear owns the single write port while the sweep runs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= INIT_VAL;
      end
    end else if (w_busy) begin
      r_ctr[r_ptr] <= INIT_VAL;
    end else if (w_upd_we) begin
      r_ctr[upd_index] <= w_upd_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_busy) begin
      r_ptr <= r_ptr + 1'b1;
    end else if (clear_req) begin
      r_ptr <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (w_busy && (r_ptr == '0)) begin
      r_ghr <= '0;
    end else if (w_upd_we && (HIST_BITS > 0)) begin
      r_ghr <= GHR_W'({r_ghr, upd_taken});
    end
  end

endmodule

// File: tb/tb_bp_pht.sv
// tb/tb_bp_pht.sv - randomized and directed self-checking bench for bp_pht against a behavioural table model
module tb_bp_pht;

  logic        clock = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [5:0]  pred_index;
  logic        upd_valid;
  logic [5:0]  upd_index;
  logic        upd_taken;
  logic        clear_req;
  logic        busy;
  logic [5:0]  ghr;

  int n_asserts = 0;
  int n_fail    = 0;

  int m_ctr [64];
  int m_ghr;
  int m_left;

  logic       last_pred;
  logic       last_busy;
  logic [5:0] last_idx;

  bp_pht dut (
    .clock      (clock),
    .reset      (reset),
    .pred_valid (pred_valid),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .pred_index (pred_index),
    .upd_valid  (upd_valid),
    .upd_index  (upd_index),
    .upd_taken  (upd_taken),
    .clear_req  (clear_req),
    .busy       (busy),
    .ghr        (ghr)
  );

  always #5 clock = ~clock;

  function automatic int sat(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    int r;
    r = $urandom();
    return (32'(r) & 32'hFFFF_FF03) | (32'((idx ^ m_ghr) & 63) << 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0;
    upd_index = '0; upd_taken = 1'b0; clear_req = 1'b0;
    @(posedge clock);
    foreach (m_ctr[i]) m_ctr[i] = 0;
    m_ghr  = 0;
    m_left = 0;
    #1;
    reset = 1'b0;
  endtask

  task automatic do_cycle(input bit pv, input logic [31:0] pc, input bit uv,
                          input int ui, input bit ut, input bit cr);
    int eidx;
    bit ebusy;
    bit epred;
    pred_valid = pv; pred_pc = pc; upd_valid = uv;
    upd_index = 6'(ui); upd_taken = ut; clear_req = cr;
    @(negedge clock);
    ebusy = (m_left > 0);
    eidx  = ((int'(pc) >> 2) & 63) ^ m_ghr;
    if (!pv || ebusy) epred = 1'b0;
    else if (uv && (ui == eidx)) epred = (sat(m_ctr[ui], ut) >= 2);
    else epred = (m_ctr[eidx] >= 2);
    last_pred = pred_taken;
    last_busy = busy;
    last_idx  = pred_index;
    chk("pred_taken", 32'(pred_taken), 32'(epred));
    chk("pred_index", 32'(pred_index), 32'(eidx));
    chk("busy", 32'(busy), 32'(ebusy));
    chk("ghr", 32'(ghr), 32'(m_ghr));
    @(posedge clock);
    if (ebusy) begin
      if (m_left == 64) m_ghr = 0;
      m_left--;
    end else begin
      if (uv) begin
        m_ctr[ui] = sat(m_ctr[ui], ut);
        m_ghr = ((m_ghr << 1) | int'(ut)) & 63;
      end
      if (cr) begin
        m_left = 64;
        foreach (m_ctr[i]) m_ctr[i] = 0;
      end
    end
    #1;
  endtask

  initial begin
    bit exp_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit exp_n [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int cnt;

    do_reset();
    do_reset();
    @(negedge clock);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ghr", 32'(ghr), 32'd0);
    chk("reset_pred", 32'(pred_taken), 32'd0);
    @(posedge clock); #1;

    for (int p = 0; p < 64; p++) begin
      do_cycle(1'b1, 32'(p * 4), 1'b0, 0, 1'b0, 1'b0);
      chk("init_pred", 32'(last_pred), 32'd0);
      chk("init_idx", 32'(last_idx), 32'(p));
    end

    // Saturating up/down on index 5, observed through the same-cycle bypass.
    for (int k = 0; k < 4; k++) begin
      do_cycle(1'b1, pc_for(5), 1'b1, 5, 1'b1, 1'b0);
      chk("sat_up", 32'(last_pred), 32'(exp_t[k]));
    end
    for (int k = 0; k < 4; k++) begin
      do_cycle(1'b1, pc_for(5), 1'b1, 5, 1'b0, 1'b0);
      chk("sat_dn", 32'(last_pred), 32'(exp_n[k]));
    end
    do_cycle(1'b1, pc_for(5), 1'b1, 5, 1'b1, 1'b0);
    chk("sat_floor", 32'(last_pred), 32'd0);

    do_reset();
    do_cycle(1'b0, 32'h0, 1'b1, 9, 1'b1, 1'b0);
    do_cycle(1'b1, pc_for(9), 1'b0, 0, 1'b0, 1'b0);
    chk("wn_pred", 32'(last_pred), 32'd0);
    do_cycle(1'b1, pc_for(9), 1'b1, 9, 1'b1, 1'b0);
    chk("bypass", 32'(last_pred), 32'd1);

    do_reset();
    do_cycle(1'b0, 32'h0, 1'b1, 0, 1'b1, 1'b0);
    do_cycle(1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b0);
    do_cycle(1'b0, 32'h0, 1'b1, 0, 1'b1, 1'b0);
    do_cycle(1'b1, 32'h40, 1'b0, 0, 1'b0, 1'b0);
    chk("ghr_101", 32'(ghr), 32'h05);
    chk("gshare_idx", 32'(last_idx), 32'd21);

    for (int k = 0; k < 400; k++) begin
      int ui;
      logic [31:0] pc;
      ui = int'($urandom_range(0, 7));
      pc = ($urandom_range(0, 1) == 1) ? pc_for(ui) : 32'($urandom());
      do_cycle(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)), ui,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 79) == 0));
    end
    while (m_left > 0) do_cycle(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 3; k++)
        do_cycle(1'b0, 32'h0, 1'b1, i, 1'b1, 1'b0);
    do_cycle(1'b1, pc_for(33), 1'b0, 0, 1'b0, 1'b0);
    chk("trained", 32'(last_pred), 32'd1);

    do_cycle(1'b1, pc_for(3), 1'b1, 3, 1'b1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      do_cycle(1'b1, 32'($urandom()), 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
               1'($urandom_range(0, 1)), (m_left > 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (last_busy) cnt++;
      else break;
    end
    chk("busy_len", 32'(cnt), 32'd64);
    chk("post_clear_ghr", 32'(ghr), 32'd0);
    for (int i = 0; i < 64; i++) begin
      do_cycle(1'b1, pc_for(i), 1'b0, 0, 1'b0, 1'b0);
      chk("post_clear_pred", 32'(last_pred), 32'd0);
    end

    do_cycle(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) do_cycle(1'b1, 32'($urandom()), 1'b1, 7, 1'b1, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    do_reset();
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ghr", 32'(ghr), 32'd0);
    @(posedge clock); #1;
    do_cycle(1'b1, 32'h1C, 1'b1, 7, 1'b1, 1'b0);
    do_cycle(1'b1, pc_for(7), 1'b0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
